// File: rtl/mem_data_resp64_pkg.sv
// Shared execute-stage memory constants: status codes, access sizes,
// response FSM states and small decode helpers.
package mem_data_resp64_pkg;

  localparam logic [1:0] UMEM_OK_READY = 2'd0;
  localparam logic [1:0] UMEM_OK_OK    = 2'd1;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'd2;
  localparam logic [1:0] UMEM_OK_FAULT = 2'd3;

  localparam logic [1:0] MEM_SZ_8  = 2'd0;
  localparam logic [1:0] MEM_SZ_16 = 2'd1;
  localparam logic [1:0] MEM_SZ_32 = 2'd2;
  localparam logic [1:0] MEM_SZ_64 = 2'd3;

  // Last counter value still spent waiting; 255 BUS cycles in total.
  localparam logic [7:0] BUS_TIMEOUT_LAST = 8'd254;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } memRespState_t;

  function automatic logic isMisaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      MEM_SZ_16: return off[0];
      MEM_SZ_32: return |off[1:0];
      MEM_SZ_64: return |off;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] sizeByteEn(input logic [1:0] size);
    case (size)
      MEM_SZ_8:  return 8'h01;
      MEM_SZ_16: return 8'h03;
      MEM_SZ_32: return 8'h0F;
      default:   return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extract64.sv
// Load lane extraction: pick the addressed lane from a 64-bit bus word,
// truncate to the access size and sign- or zero-extend.
module mem_load_extract64 (
  input  logic [63:0] rdata,
  input  logic [2:0]  addr,
  input  logic [2:0]  mode,
  output logic [63:0] value
);
  import mem_data_resp64_pkg::*;

  logic [63:0] shifted;
  logic        zext;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    zext    = mode[2];
    case (mode[1:0])
      MEM_SZ_8:  value = zext ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      MEM_SZ_16: value = zext ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      MEM_SZ_32: value = zext ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default:   value = shifted;
    endcase
  end

endmodule

// File: rtl/mem_data_resp64.sv
// Execute-stage data memory responder: accepts one load/store from execute,
// runs it as a single aligned 64-bit bus transfer and reports status.
module mem_data_resp64 (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] memAddr,
  input  logic [63:0] memData,
  input  logic        memLoad,
  input  logic        memStore,
  input  logic [4:0]  memOpMode,
  input  logic [7:0]  memOpCmd2,
  output logic [63:0] memOutData,
  output logic [7:0]  memOutCmd2,
  output logic [1:0]  memOK,
  output logic [63:0] busAddr,
  output logic [63:0] busWData,
  output logic [7:0]  busByteEn,
  output logic        busRead,
  output logic        busWrite,
  input  logic [63:0] busRData,
  input  logic        busAck
);
  import mem_data_resp64_pkg::*;

  memRespState_t state, stateNext;
  logic [7:0]    timeout;
  logic          opLoad;
  logic [2:0]    opAddrLo;
  logic [2:0]    opMode;
  logic          accept;
  logic [63:0]   loadValue;
  logic          unusedModeBits;

  assign unusedModeBits = ^memOpMode[4:3];

  mem_load_extract64 uExtract (
    .rdata (busRData),
    .addr  (opAddrLo),
    .mode  (opMode),
    .value (loadValue)
  );

  // Strobes decode from state so an asynchronous reset removes them at once.
  assign busRead  = (state == ST_BUS) &&  opLoad;
  assign busWrite = (state == ST_BUS) && !opLoad;

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    memOK     = UMEM_OK_READY;
    case (state)
      ST_IDLE: begin
        if (memLoad || memStore) begin
          memOK = UMEM_OK_HOLD;
          if ((memLoad && memStore) || isMisaligned(memOpMode[1:0], memAddr[2:0])) begin
            stateNext = ST_FAULT;
          end else begin
            stateNext = ST_BUS;
            accept    = 1'b1;
          end
        end
      end
      ST_BUS: begin
        memOK = UMEM_OK_HOLD;
        if (busAck) begin
          stateNext = ST_DONE;
        end else if (timeout == BUS_TIMEOUT_LAST) begin
          stateNext = ST_FAULT;
        end
      end
      ST_DONE: begin
        memOK     = UMEM_OK_OK;
        stateNext = ST_IDLE;
      end
      default: begin
        memOK     = UMEM_OK_FAULT;
        stateNext = ST_IDLE;
      end
    endcase
    if (reset) begin
      memOK = UMEM_OK_READY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      timeout    <= '0;
      opLoad     <= 1'b0;
      opAddrLo   <= '0;
      opMode     <= '0;
      memOutData <= '0;
      memOutCmd2 <= '0;
      busAddr    <= '0;
      busWData   <= '0;
      busByteEn  <= '0;
    end else begin
      state <= stateNext;
      if (state == ST_BUS && !busAck) begin
        timeout <= timeout + 8'd1;
      end else begin
        timeout <= '0;
      end
      if (accept) begin
        opLoad     <= memLoad;
        opAddrLo   <= memAddr[2:0];
        opMode     <= memOpMode[2:0];
        memOutCmd2 <= memOpCmd2;
        busAddr    <= {memAddr[63:3], 3'b000};
        busWData   <= memData << {memAddr[2:0], 3'b000};
        busByteEn  <= sizeByteEn(memOpMode[1:0]) << memAddr[2:0];
      end
      if (state == ST_BUS && busAck && opLoad) begin
        memOutData <= loadValue;
      end
      // Clearing on entry makes the FAULT cycle read zero and keeps it held after.
      if (stateNext == ST_FAULT) begin
        memOutData <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_data_resp64.sv
// Randomized and directed bench for mem_data_resp64 against a transaction-level model.
module tb_mem_data_resp64;

  localparam logic [1:0] OK_READY = 2'd0;
  localparam logic [1:0] OK_OK    = 2'd1;
  localparam logic [1:0] OK_HOLD  = 2'd2;
  localparam logic [1:0] OK_FAULT = 2'd3;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] memAddr, memData, busRData;
  logic        memLoad, memStore, busAck;
  logic [4:0]  memOpMode;
  logic [7:0]  memOpCmd2;
  logic [63:0] memOutData, busAddr, busWData;
  logic [7:0]  memOutCmd2, busByteEn;
  logic [1:0]  memOK;
  logic        busRead, busWrite;

  int checks = 0;
  int errors = 0;
  logic [63:0] expOut = '0;

  mem_data_resp64 dut (
    .clock(clock), .reset(reset),
    .memAddr(memAddr), .memData(memData), .memLoad(memLoad), .memStore(memStore),
    .memOpMode(memOpMode), .memOpCmd2(memOpCmd2),
    .memOutData(memOutData), .memOutCmd2(memOutCmd2), .memOK(memOK),
    .busAddr(busAddr), .busWData(busWData), .busByteEn(busByteEn),
    .busRead(busRead), .busWrite(busWrite), .busRData(busRData), .busAck(busAck)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] refLoad(input logic [63:0] rdata, input int off,
                                          input int size, input bit zext);
    int nb = 1 << size;
    logic [63:0] sh   = rdata >> (8 * off);
    logic [63:0] mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    logic [63:0] val  = sh & mask;
    if (!zext && sh[8 * nb - 1]) val = val | ~mask;
    return val;
  endfunction

  function automatic logic [7:0] refByteEn(input int size, input int off);
    logic [15:0] t = ((16'd1 << (1 << size)) - 16'd1) << off;
    return t[7:0];
  endfunction

  // Entered and left a few ns after a rising edge, with the DUT in IDLE.
  // ackDelay < 0 means busAck is never given.
  task automatic doAccess(input string name, input bit ld, input bit st,
                          input logic [63:0] addr, input logic [63:0] data,
                          input logic [4:0] mode, input logic [7:0] cmd,
                          input logic [63:0] rdata, input int ackDelay);
    int off  = int'(addr[2:0]);
    int size = int'(mode[1:0]);
    bit isFault = (ld && st) || ((off % (1 << size)) != 0);
    int busCycles = 0;
    memLoad = ld; memStore = st; memAddr = addr; memData = data;
    memOpMode = mode; memOpCmd2 = cmd;
    #2;
    checkVal({name, ".reqHold"}, memOK, OK_HOLD);
    checkVal({name, ".reqNoStrobe"}, {busRead, busWrite}, 2'b00);
    nextCycle();
    // Inputs outside IDLE must not matter.
    memLoad = 1'b0; memStore = 1'b0;
    memAddr = {$urandom, $urandom}; memData = {$urandom, $urandom};
    memOpMode = 5'($urandom); memOpCmd2 = 8'($urandom);
    #2;
    if (isFault) begin
      expOut = '0;
      checkVal({name, ".faultOk"}, memOK, OK_FAULT);
      checkVal({name, ".faultData"}, memOutData, 64'd0);
      checkVal({name, ".faultNoStrobe"}, {busRead, busWrite}, 2'b00);
    end else begin
      for (int k = 0; k < 300; k++) begin
        if (ackDelay < 0 && k == 255) break;
        busCycles++;
        checkVal({name, ".busHold"}, memOK, OK_HOLD);
        checkVal({name, ".busStrobe"}, {busRead, busWrite}, {ld, st});
        if (k == 0) begin
          checkVal({name, ".busAddr"}, busAddr, {addr[63:3], 3'b000});
          if (st) begin
            checkVal({name, ".busByteEn"}, busByteEn, refByteEn(size, off));
            checkVal({name, ".busWData"}, busWData, data << (8 * off));
          end
        end
        if (k == ackDelay) begin
          busAck = 1'b1; busRData = rdata;
          nextCycle();
          busAck = 1'b0; busRData = {$urandom, $urandom};
          #2;
          break;
        end
        nextCycle();
        #2;
      end
      if (ackDelay >= 0) begin
        if (ld) expOut = refLoad(rdata, off, size, mode[2]);
        checkVal({name, ".busCycles"}, busCycles, ackDelay + 1);
        checkVal({name, ".doneOk"}, memOK, OK_OK);
        checkVal({name, ".doneNoStrobe"}, {busRead, busWrite}, 2'b00);
        checkVal({name, ".doneData"}, memOutData, expOut);
        checkVal({name, ".doneCmd2"}, memOutCmd2, cmd);
      end else begin
        expOut = '0;
        checkVal({name, ".tmoCycles"}, busCycles, 255);
        checkVal({name, ".tmoFault"}, memOK, OK_FAULT);
        checkVal({name, ".tmoNoStrobe"}, {busRead, busWrite}, 2'b00);
        checkVal({name, ".tmoData"}, memOutData, 64'd0);
      end
    end
    nextCycle();
    #2;
    checkVal({name, ".backReady"}, memOK, OK_READY);
    checkVal({name, ".heldData"}, memOutData, expOut);
  endtask

  initial begin
    reset = 1'b1; memLoad = 1'b0; memStore = 1'b0; busAck = 1'b0;
    memAddr = '0; memData = '0; memOpMode = '0; memOpCmd2 = '0; busRData = '0;
    #1;
    checkVal("rst.memOK", memOK, OK_READY);
    checkVal("rst.outData", memOutData, 64'd0);
    checkVal("rst.outCmd2", memOutCmd2, 8'd0);
    checkVal("rst.strobes", {busRead, busWrite}, 2'b00);
    checkVal("rst.busAddr", busAddr, 64'd0);
    checkVal("rst.busWData", busWData, 64'd0);
    checkVal("rst.byteEn", busByteEn, 8'd0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
    #2;
    checkVal("idle.ready", memOK, OK_READY);

    doAccess("ld8s", 1, 0, 64'h1005, 64'h0, 5'b00000, 8'h11,
             64'h0000_8000_0000_0000, 1);
    checkVal("ld8s.value", memOutData, 64'hFFFF_FFFF_FFFF_FF80);
    doAccess("st16", 0, 1, 64'h2006, 64'hBEEF, 5'b00001, 8'h22, 64'h0, 0);
    doAccess("ld32mis", 1, 0, 64'h3002, 64'h0, 5'b00010, 8'h33, 64'h0, 0);
    doAccess("both", 1, 1, 64'h0, 64'h0, 5'b00011, 8'h44, 64'h0, 0);
    doAccess("ld64tmo", 1, 0, 64'h4000, 64'h0, 5'b00011, 8'h55, 64'h0, -1);

    for (int i = 0; i < 60; i++) begin
      logic [63:0] a = {$urandom, $urandom};
      logic [4:0]  m = 5'($urandom);
      int kind = int'($urandom_range(0, 9));
      if ($urandom_range(0, 9) < 7) a = a & ~((64'd1 << m[1:0]) - 64'd1);
      if ($urandom_range(0, 4) == 0) begin
        memLoad = 1'b0; memStore = 1'b0;
        #2;
        checkVal("rnd.idleReady", memOK, OK_READY);
        nextCycle();
        #2;
      end
      doAccess("rnd", kind < 5, (kind >= 5 && kind < 9) || kind == 9 ? 1'b1 : 1'b0,
               a, {$urandom, $urandom}, m, 8'($urandom_range(1, 255)),
               {$urandom, $urandom}, int'($urandom_range(0, 4)));
    end

    // Reset mid-BUS: strobe drops immediately and a late ack is ignored.
    memLoad = 1'b1; memAddr = 64'h5008; memOpMode = 5'b00011; memOpCmd2 = 8'h66;
    #2;
    checkVal("rstBus.reqHold", memOK, OK_HOLD);
    nextCycle();
    memLoad = 1'b0;
    #2;
    checkVal("rstBus.strobe", busRead, 1'b1);
    nextCycle();
    #2;
    reset = 1'b1;
    #1;
    checkVal("rstBus.strobeDrop", {busRead, busWrite}, 2'b00);
    checkVal("rstBus.ready", memOK, OK_READY);
    checkVal("rstBus.outData", memOutData, 64'd0);
    checkVal("rstBus.outCmd2", memOutCmd2, 8'd0);
    checkVal("rstBus.busAddr", busAddr, 64'd0);
    checkVal("rstBus.byteEn", busByteEn, 8'd0);
    expOut = '0;
    nextCycle();
    busAck = 1'b1; busRData = 64'hDEAD_BEEF_0123_4567;
    #2;
    checkVal("rstBus.ackReady", memOK, OK_READY);
    nextCycle();
    busAck = 1'b0; reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      checkVal("rstBus.postReady", memOK, OK_READY);
      checkVal("rstBus.postStrobe", {busRead, busWrite}, 2'b00);
      checkVal("rstBus.postData", memOutData, expOut);
      nextCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
